// File: rtl/dozen_fifo.sv
// First-word-fall-through FIFO for camera dozens with metadata/pixel flags.
// Optional almost_full output when DOZEN_FIFO_ALMOST_FULL_EN is defined.
module dozen_fifo #(
  parameter int DATA_W    = 12,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          in_dozen,
  input  logic                       in_metadata_flag,
  input  logic                       in_pixel_data_flag,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_dozen,
  output logic                       out_metadata_flag,
  output logic                       out_pixel_data_flag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow_err,
  output logic                       flag_err
`ifdef DOZEN_FIFO_ALMOST_FULL_EN
  ,
  output logic                       almost_full
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0 || AF_MARGIN < 1 || AF_MARGIN >= DEPTH) begin : g_bad_param
    $error("dozen_fifo: illegal DEPTH or AF_MARGIN");
  end

  typedef struct packed {
    logic              meta;
    logic              pix;
    logic [DATA_W-1:0] dozen;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wptr, rptr;
  logic [LW-1:0]   lvl_q, lvl_nxt;
  logic            run_q;
  logic            wr, rd;

  assign in_ready  = (lvl_q != FULL_LVL);
  assign out_valid = (lvl_q != '0);
  assign level     = lvl_q;

  // run_q holds off writes until one edge after reset release.
  assign wr = in_valid & in_ready & run_q & ~flush;
  assign rd = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= '{meta: in_metadata_flag, pix: in_pixel_data_flag, dozen: in_dozen};
  end

  always_comb begin
    lvl_nxt = lvl_q;
    if (flush) lvl_nxt = '0;
    else begin
      case ({wr, rd})
        2'b10:   lvl_nxt = lvl_q + LW'(1);
        2'b01:   lvl_nxt = lvl_q - LW'(1);
        default: lvl_nxt = lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_nxt;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr) wptr <= wptr + PW'(1);
        if (rd) rptr <= rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
      flag_err     <= 1'b0;
    end else if (flush) begin
      overflow_err <= 1'b0;
      flag_err     <= 1'b0;
    end else begin
      if (in_valid && !in_ready)                         overflow_err <= 1'b1;
      if (wr && in_metadata_flag && in_pixel_data_flag) flag_err     <= 1'b1;
    end
  end

  assign head = mem[rptr];

  // Head is masked so an empty FIFO never exposes stale memory.
  always_comb begin
    out_dozen           = '0;
    out_metadata_flag   = 1'b0;
    out_pixel_data_flag = 1'b0;
    if (out_valid) begin
      out_dozen           = head.dozen;
      out_metadata_flag   = head.meta;
      out_pixel_data_flag = head.pix;
    end
  end

`ifdef DOZEN_FIFO_ALMOST_FULL_EN
  localparam logic [LW-1:0] AF_LVL = LW'(DEPTH - AF_MARGIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) almost_full <= 1'b0;
    else        almost_full <= (lvl_nxt >= AF_LVL);
  end
`endif

endmodule

// File: tb/tb_dozen_fifo.sv
// Randomised bench for dozen_fifo against a queue-based reference model.
module tb_dozen_fifo;
  localparam int DATA_W    = 12;
  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 2;
  localparam int LW        = $clog2(DEPTH+1);
  localparam int ST        = DATA_W + LW + 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] in_dozen = '0;
  logic              in_metadata_flag = 1'b0;
  logic              in_pixel_data_flag = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_dozen;
  logic              out_metadata_flag;
  logic              out_pixel_data_flag;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LW-1:0]     level;
  logic              overflow_err;
  logic              flag_err;
`ifdef DOZEN_FIFO_ALMOST_FULL_EN
  logic              almost_full;
`endif

  dozen_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_dozen(in_dozen), .in_metadata_flag(in_metadata_flag),
    .in_pixel_data_flag(in_pixel_data_flag), .in_valid(in_valid), .in_ready(in_ready),
    .out_dozen(out_dozen), .out_metadata_flag(out_metadata_flag),
    .out_pixel_data_flag(out_pixel_data_flag), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow_err(overflow_err), .flag_err(flag_err)
`ifdef DOZEN_FIFO_ALMOST_FULL_EN
    , .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {meta, pix, dozen}, sticky flags, write enable after reset.
  logic [DATA_W+1:0] q[$];
  bit m_run = 1'b0, m_ovf = 1'b0, m_ferr = 1'b0;
  int n_acc;

  logic [ST-1:0] dut_state;
  assign dut_state = {out_valid, out_metadata_flag, out_pixel_data_flag, out_dozen,
                      level, in_ready, overflow_err, flag_err};

  function automatic logic [ST-1:0] model_state();
    logic [DATA_W+1:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    return {q.size() != 0, h, LW'(q.size()), q.size() != DEPTH, m_ovf, m_ferr};
  endfunction

  // Drive one cycle, advance past the edge and update the model.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit mf, input bit pf,
                       input bit rdy, input bit fl);
    bit wr, rd;
    in_valid = v; in_dozen = d; in_metadata_flag = mf; in_pixel_data_flag = pf;
    out_ready = rdy; flush = fl;
    wr = v && m_run && (q.size() < DEPTH) && !fl;
    rd = rdy && (q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    end else begin
      if (v && q.size() == DEPTH) m_ovf = 1'b1;
      if (rd) void'(q.pop_front());
      if (wr) begin
        q.push_back({mf, pf, d});
        if (mf && pf) m_ferr = 1'b1;
      end
    end
    n_acc += int'(wr);
    m_run = 1'b1;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    if (dut_state !== {1'b0, {(DATA_W+2){1'b0}}, LW'(0), 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state got %h exp all-zero with in_ready=1", dut_state);
    end
    checks++;
`ifdef DOZEN_FIFO_ALMOST_FULL_EN
    if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
    checks++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); m_run = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    idle();
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    if (level !== LW'(3) || out_dozen !== 12'h001 || out_valid !== 1'b1 || out_pixel_data_flag !== 1'b1) begin
      errors++; $display("FAIL basic_fill got lvl=%0d head=%h v=%b exp lvl=3 head=001 v=1", level, out_dozen, out_valid);
    end
    checks++;
    for (int i = 1; i <= 3; i++) begin
      if (out_dozen !== DATA_W'(i) || out_valid !== 1'b1) begin
        errors++; $display("FAIL basic_order got %h exp %h", out_dozen, DATA_W'(i));
      end
      checks++;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    if (out_valid !== 1'b0 || level !== LW'(0) || out_dozen !== '0) begin
      errors++; $display("FAIL basic_empty got v=%b lvl=%0d d=%h exp 0/0/0", out_valid, level, out_dozen);
    end
    checks++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'(12'hA00 + i), 1'b0, 1'b1, 1'b0, 1'b0);
    if (in_ready !== 1'b0 || level !== LW'(DEPTH)) begin
      errors++; $display("FAIL ovf_full got rdy=%b lvl=%0d exp 0/16", in_ready, level);
    end
    checks++;
    cycle(1'b1, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    if (overflow_err !== 1'b1 || level !== LW'(DEPTH)) begin
      errors++; $display("FAIL ovf_flag got err=%b lvl=%0d exp 1/16", overflow_err, level);
    end
    checks++;
    for (int i = 0; i < DEPTH; i++) begin
      if (out_dozen !== DATA_W'(12'hA00 + i)) begin
        errors++; $display("FAIL ovf_drain got %h exp %h", out_dozen, DATA_W'(12'hA00 + i));
      end
      checks++;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    if (out_valid !== 1'b0 || overflow_err !== 1'b1) begin
      errors++; $display("FAIL ovf_after got v=%b err=%b exp 0/1", out_valid, overflow_err);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'(12'hB00 + i), 1'b0, 1'b1, 1'b0, 1'b0);
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      d = DATA_W'(12'hC00 + n_acc);
      cycle(1'b1, d, 1'b0, 1'b1, 1'b1, 1'b0);
      if (dut_state !== model_state()) begin
        errors++; $display("FAIL b2b_cycle%0d got %h exp %h", i, dut_state, model_state());
      end
      checks++;
    end
    if (n_acc != 19 || level !== LW'(DEPTH-1)) begin
      errors++; $display("FAIL b2b_count got acc=%0d lvl=%0d exp 19/15", n_acc, level);
    end
    checks++;
    while (q.size() != 0) begin
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (dut_state !== model_state()) begin
        errors++; $display("FAIL b2b_drain got %h exp %h", dut_state, model_state());
      end
      checks++;
    end
  endtask

  task automatic test_flags_flush();
    cycle(1'b1, 12'h5A5, 1'b1, 1'b1, 1'b0, 1'b0);
    if (flag_err !== 1'b1 || {out_metadata_flag, out_pixel_data_flag, out_dozen} !== {2'b11, 12'h5A5}) begin
      errors++; $display("FAIL flag_err got err=%b head=%b%b_%h exp 1 11_5a5",
                         flag_err, out_metadata_flag, out_pixel_data_flag, out_dozen);
    end
    checks++;
    cycle(1'b1, 12'h777, 1'b0, 1'b1, 1'b1, 1'b1);
    if (level !== LW'(0) || flag_err !== 1'b0 || overflow_err !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush got lvl=%0d ferr=%b oerr=%b v=%b exp 0/0/0/0",
                         level, flag_err, overflow_err, out_valid);
    end
    checks++;
    idle();
    if (out_valid !== 1'b0 || level !== LW'(0)) begin
      errors++; $display("FAIL flush_nostore got v=%b lvl=%0d exp 0/0", out_valid, level);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
    if (level !== LW'(8)) begin errors++; $display("FAIL arst_pre got lvl=%0d exp 8", level); end
    checks++;
    #1 rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0 || level !== LW'(0)) begin
      errors++; $display("FAIL arst_async got v=%b lvl=%0d exp 0/0", out_valid, level);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); m_run = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    cycle(1'b1, 12'h3C3, 1'b0, 1'b1, 1'b0, 1'b0);
    if (level !== LW'(0)) begin errors++; $display("FAIL arst_first_edge got lvl=%0d exp 0", level); end
    checks++;
    cycle(1'b1, 12'h3C3, 1'b0, 1'b1, 1'b0, 1'b0);
    if (level !== LW'(1) || out_dozen !== 12'h3C3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL arst_second_edge got lvl=%0d head=%h exp 1/3c3", level, out_dozen);
    end
    checks++;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit v, rdy, fl, mf, pf;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0) || (i > 200 && $urandom_range(0, 1) == 0);
      fl  = ($urandom_range(0, 59) == 0);
      mf  = ($urandom_range(0, 4) == 0);
      pf  = ($urandom_range(0, 1) == 0);
      cycle(v, DATA_W'($urandom), mf, pf, rdy, fl);
      if (dut_state !== model_state()) begin
        errors++; $display("FAIL rand_cycle%0d got %h exp %h", i, dut_state, model_state());
      end
      checks++;
`ifdef DOZEN_FIFO_ALMOST_FULL_EN
      if (almost_full !== (q.size() >= DEPTH - AF_MARGIN)) begin
        errors++; $display("FAIL rand_af%0d got %b exp %b", i, almost_full, q.size() >= DEPTH - AF_MARGIN);
      end
      checks++;
`endif
    end
  endtask

`ifdef DOZEN_FIFO_ALMOST_FULL_EN
  task automatic test_almost_full();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    if (almost_full !== 1'b0) begin errors++; $display("FAIL af_13 got %b exp 0", almost_full); end
    checks++;
    cycle(1'b1, 12'h0EE, 1'b0, 1'b1, 1'b0, 1'b0);
    if (almost_full !== 1'b1) begin errors++; $display("FAIL af_14 got %b exp 1", almost_full); end
    checks++;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (almost_full !== 1'b0) begin errors++; $display("FAIL af_read got %b exp 0", almost_full); end
    checks++;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    n_acc = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_flags_flush();
    test_async_reset();
`ifdef DOZEN_FIFO_ALMOST_FULL_EN
    test_almost_full();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
